// File: rtl/organ_footage_engine.sv
// Organ tone engine: 12 top-octave dividers drive octave counters; a 128-key scanner sums the
// tone of each held key per footage rank, scales by drawbar level and emits PWM. Option: ORGAN_SUSTAIN_EN.
module organ_footage_engine #(
  parameter int NUM_FOOT = 4,
  parameter int PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                note_on,
  input  logic                note_off,
  input  logic [6:0]          note,
  input  logic                all_off,
  input  logic                sustain,
  input  logic                lvl_we,
  input  logic [1:0]          lvl_sel,
  input  logic [6:0]          lvl_data,
  output logic [NUM_FOOT-1:0] foot_pwm,
  output logic                mix_pwm,
  output logic                key_any
);

  localparam int MIX_SH = (NUM_FOOT > 1) ? $clog2(NUM_FOOT) : 0;
  localparam int MIX_W  = PWM_W + 2;
  localparam logic [13:0] DIV [12] = '{14'd11945, 14'd11274, 14'd10641, 14'd10044,
                                       14'd9480,  14'd8948,  14'd8446,  14'd7972,
                                       14'd7525,  14'd7102,  14'd6704,  14'd6327};

  logic [13:0]         div_cnt_q [12];
  logic [11:0]         sq_q, sq_dly_q;
  logic [10:0]         oct_q [12];
  logic [6:0]          scan_q;
  logic [127:0]        key_q, key_d;
  logic                key_any_q;
  logic [7:0]          acc_q [NUM_FOOT];
  logic [7:0]          sum_q [NUM_FOOT];
  logic                vld_p1_q;
  logic [6:0]          level_q [NUM_FOOT];
  logic [PWM_W-1:0]    samp_q [NUM_FOOT];
  logic [PWM_W-1:0]    samp_w [NUM_FOOT];
  logic [PWM_W-1:0]    mix_q;
  logic [MIX_W-1:0]    mix_sum_w;
  logic [PWM_W-1:0]    pwm_cnt_q;
  logic [NUM_FOOT-1:0] foot_q;
  logic                mix_out_q;
  logic [6:0]          m_w;
  logic [3:0]          semi_w, oidx_w;
  logic [NUM_FOOT-1:0] add_w;

  function automatic logic [PWM_W-1:0] scale_sat(input logic [7:0] sum, input logic [6:0] lvl);
    logic [14:0]      prod;
    logic [PWM_W+7:0] wide;
    prod      = 15'(sum) * 15'(lvl);
    wide      = '0;
    wide[7:0] = prod[14:7];
    wide      = wide << (PWM_W - 8);
    return (|wide[PWM_W+7:PWM_W]) ? '1 : wide[PWM_W-1:0];
  endfunction

  // Stage: dividers and octave counters (edges of each square wave seen one cycle late)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_q     <= '0;
      sq_dly_q <= '0;
      for (int s = 0; s < 12; s++) begin
        div_cnt_q[s] <= '0;
        oct_q[s]     <= '0;
      end
    end else begin
      sq_dly_q <= sq_q;
      for (int s = 0; s < 12; s++) begin
        if (div_cnt_q[s] == DIV[s] - 14'd1) begin
          div_cnt_q[s] <= '0;
          sq_q[s]      <= ~sq_q[s];
        end else begin
          div_cnt_q[s] <= div_cnt_q[s] + 14'd1;
        end
        if (sq_q[s] ^ sq_dly_q[s]) oct_q[s] <= oct_q[s] + 11'd1;
      end
    end
  end

  // Note 127 maps to the top semitone of the lowest-index octave bit.
  always_comb begin
    logic [3:0] ob;
    m_w    = 7'd127 - scan_q;
    semi_w = 4'd11 - 4'(m_w % 7'd12);
    oidx_w = 4'(m_w / 7'd12);
    add_w  = '0;
    ob     = '0;
    for (int f = 0; f < NUM_FOOT; f++) begin
      ob = oidx_w - 4'(f);
      if (oidx_w >= 4'(f) && ob <= 4'd9)
        add_w[f] = key_q[scan_q] & oct_q[semi_w][ob];
    end
  end

`ifdef ORGAN_SUSTAIN_EN
  logic [127:0] pend_q, pend_d;
  logic         sus_q;

  always_comb begin
    key_d  = key_q;
    pend_d = pend_q;
    if (all_off) begin
      key_d  = '0;
      pend_d = '0;
    end else begin
      if (sus_q && !sustain) begin
        key_d  = key_q & ~pend_q;
        pend_d = '0;
      end
      if (note_on) begin
        key_d[note]  = 1'b1;
        pend_d[note] = 1'b0;
      end else if (note_off) begin
        if (sustain) pend_d[note] = 1'b1;
        else         key_d[note]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      sus_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      sus_q  <= sustain;
    end
  end
`else
  logic unused_sustain;
  assign unused_sustain = sustain;

  always_comb begin
    key_d = key_q;
    if (all_off)       key_d       = '0;
    else if (note_on)  key_d[note] = 1'b1;
    else if (note_off) key_d[note] = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= '0;
      key_any_q <= 1'b0;
    end else begin
      key_q     <= key_d;
      key_any_q <= |key_q;
    end
  end

  // Stage p0: scan and per-rank accumulation; sum is latched at the end of each 128-cycle scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_q   <= '0;
      vld_p1_q <= 1'b0;
      for (int f = 0; f < NUM_FOOT; f++) begin
        acc_q[f] <= '0;
        sum_q[f] <= '0;
      end
    end else begin
      scan_q   <= scan_q + 7'd1;
      vld_p1_q <= (scan_q == 7'd127);
      for (int f = 0; f < NUM_FOOT; f++) begin
        if (scan_q == 7'd127) begin
          sum_q[f] <= acc_q[f] + {7'd0, add_w[f]};
          acc_q[f] <= '0;
        end else begin
          acc_q[f] <= acc_q[f] + {7'd0, add_w[f]};
        end
      end
    end
  end

  always_comb begin
    mix_sum_w = '0;
    for (int f = 0; f < NUM_FOOT; f++) begin
      samp_w[f] = scale_sat(sum_q[f], level_q[f]);
      mix_sum_w = mix_sum_w + MIX_W'(samp_w[f]);
    end
  end

  // Stage p1: drawbar-scaled samples and mix; p2: PWM comparison
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q     <= '0;
      pwm_cnt_q <= '0;
      foot_q    <= '0;
      mix_out_q <= 1'b0;
      for (int f = 0; f < NUM_FOOT; f++) begin
        samp_q[f]  <= '0;
        level_q[f] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
      mix_out_q <= (pwm_cnt_q < mix_q);
      if (vld_p1_q) mix_q <= PWM_W'(mix_sum_w >> MIX_SH);
      for (int f = 0; f < NUM_FOOT; f++) begin
        foot_q[f] <= (pwm_cnt_q < samp_q[f]);
        if (vld_p1_q) samp_q[f] <= samp_w[f];
        if (lvl_we && lvl_sel == 2'(f)) level_q[f] <= lvl_data;
      end
    end
  end

  assign foot_pwm = foot_q;
  assign mix_pwm  = mix_out_q;
  assign key_any  = key_any_q;

endmodule
